// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the PC, drives the instruction-memory
// address, predicts the next PC with a direct-mapped BTB and 2-bit BHT,
// and produces the IF/ID register consumed by decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IDX_W     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] instruction_out,
  output logic        pred_taken_out,
  output logic [31:0] pred_target_out,
  output logic        valid_out
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [31:0]      pc_p0;
  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [31:0]      btb_target [ENTRIES];
  logic [1:0]       bht        [ENTRIES];

  logic [IDX_W-1:0] idx_p0;
  logic [TAG_W-1:0] tag_p0;
  logic             hit_p0;
  logic             taken_p0;
  logic [31:0]      pred_tgt_p0;
  logic [31:0]      next_pc_p0;

  logic [IDX_W-1:0] ui;
  logic [TAG_W-1:0] ut;
  logic             uhit;

  // Low address bits are ignored: fetch and update are word-granular.
  logic unused_bits;
  assign unused_bits = ^{upd_pc[1:0], redirect_pc[1:0]};

  // Lookup on the current PC (zero-latency instruction memory)
  assign imem_addr   = pc_p0;
  assign idx_p0      = pc_p0[IDX_W+1:2];
  assign tag_p0      = pc_p0[31:IDX_W+2];
  assign hit_p0      = btb_valid[idx_p0] && (btb_tag[idx_p0] == tag_p0);
  assign taken_p0    = hit_p0 && bht[idx_p0][1];
  assign pred_tgt_p0 = taken_p0 ? btb_target[idx_p0] : 32'h0;
  assign next_pc_p0  = taken_p0 ? btb_target[idx_p0] : pc_p0 + 32'd4;

  // Update-port lookup: the resolved branch's slot and tag compare
  assign ui   = upd_pc[IDX_W+1:2];
  assign ut   = upd_pc[31:IDX_W+2];
  assign uhit = btb_valid[ui] && (btb_tag[ui] == ut);

  // PC and IF/ID register: reset > redirect > stall > advance
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0           <= RESET_PC;
      PC_out          <= 32'h0;
      instruction_out <= NOP_INSTR;
      pred_taken_out  <= 1'b0;
      pred_target_out <= 32'h0;
      valid_out       <= 1'b0;
    end else if (redirect_valid) begin
      pc_p0           <= {redirect_pc[31:2], 2'b00};
      PC_out          <= 32'h0;
      instruction_out <= NOP_INSTR;
      pred_taken_out  <= 1'b0;
      pred_target_out <= 32'h0;
      valid_out       <= 1'b0;
    end else if (!stall) begin
      pc_p0           <= next_pc_p0;
      PC_out          <= pc_p0;
      instruction_out <= imem_rdata;
      pred_taken_out  <= taken_p0;
      pred_target_out <= pred_tgt_p0;
      valid_out       <= 1'b1;
    end
  end

  // BTB valid bits and BHT counters; updates ignore stall and redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        bht[i]       <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (uhit) begin
          bht[ui] <= sat_inc(bht[ui]);
        end else begin
          btb_valid[ui] <= 1'b1;
          bht[ui]       <= 2'b10;
        end
      end else if (uhit) begin
        bht[ui] <= sat_dec(bht[ui]);
      end
    end
  end

  // BTB tag/target payload; only meaningful while the valid bit is set
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      btb_target[ui] <= upd_target;
      if (!uhit) begin
        btb_tag[ui] <= ut;
      end
    end
  end

endmodule
